fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC register, issues instruction-memory requests, and presents
//  the fetched instruction with its PC to decode. Consumes br_taken/br_target from the branch
//  comparator and ALU to redirect the PC. Tolerates multi-cycle memory latency.
//  Fetch is stage 0; branch resolution lies downstream and closes the redirect loop back here.
// PARAMETERS
//  XLEN      32            address/data width
//  RESET_PC  32'h0000_0000 first fetch address after reset (word aligned)
//  NOP_INST  32'h0000_0013 value of inst while no valid instruction is held (addi x0,x0,0)
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous reset, active-high
//  br_taken       in   1     redirect request from branch unit, one-cycle pulse
//  br_target      in   XLEN  redirect address (ALU result); sampled when br_taken=1
//  imem_req_valid out  1     memory request valid
//  imem_req_ready in   1     memory accepts request this cycle
//  imem_addr      out  XLEN  request address, always equal to pc
//  imem_rsp_valid in   1     response data valid; one response per accepted request, in order
//  imem_rsp_data  in   32    response instruction word
//  inst_valid     out  1     inst/inst_pc hold a valid instruction for decode
//  inst_ready     in   1     decode accepts inst this cycle
//  inst           out  32    fetched instruction
//  inst_pc        out  XLEN  PC of inst
//  misaligned     out  1     one-cycle pulse: br_target[1:0]!=0 on a redirect
// BEHAVIOUR
//  Reset (async, immediate): state=REQ, pc=RESET_PC, drop=0, inst_valid=0, inst=NOP_INST,
//   inst_pc=RESET_PC, misaligned=0. imem_req_valid=0 while rst=1.
//  FSM: REQ -> WAIT -> HOLD -> REQ.
//   REQ : imem_req_valid=1, imem_addr=pc. Addr held stable until imem_req_ready. On valid&&ready -> WAIT.
//   WAIT: imem_req_valid=0. On imem_rsp_valid: if drop, discard, clear drop -> REQ;
//         else register data into inst, inst_pc<=pc, inst_valid<=1 -> HOLD.
//   HOLD: inst/inst_pc stable while inst_valid && !inst_ready. On inst_ready: inst_valid<=0,
//         pc<=pc+4 -> REQ. Latency: rsp_valid to inst_valid = 1 clk; accept to next req = 1 clk.
//  Redirect (br_taken=1), priority over every other event in the same cycle:
//   pc <= {br_target[XLEN-1:2],2'b00}; inst_valid<=0; inst<=NOP_INST; misaligned<=|br_target[1:0].
//   REQ without handshake -> stay REQ with new pc. REQ with handshake this cycle -> WAIT, drop<=1.
//   WAIT without rsp -> stay WAIT, drop<=1. WAIT with rsp this cycle -> rsp discarded -> REQ.
//   HOLD (incl. simultaneous inst_ready) -> REQ; pc+4 not applied.
//  Arithmetic: pc+4 is modulo 2^XLEN (0xFFFF_FFFC wraps to 0). pc[1:0] is always 0.
//  imem_rsp_valid outside WAIT is ignored (no state change).
//  At most one outstanding memory request; no new request is issued until the response (or its
//  drop) completes.
//  Reset mid-operation: outstanding request abandoned; memory model is reset by the same rst.
// STRUCTURE
//  Shared package core_pkg: br_type_e enum (BEQ,BNE,BLT,BGE,BLTU,BGEU,PC,ALU) shared with branch,
//   fetch_state_e {REQ,WAIT,HOLD}, NOP_INST and RESET_PC defaults.
//  Single module. No sub-module: PC adder and next-PC mux are inline.
// TESTING
//  1 Reset, req_ready=1, 1-cycle rsp -> imem_addr 0x0,0x4,0x8; inst_pc matches; inst = memory word.
//  2 inst_ready=0 for 3 clks with inst_valid=1 -> inst/inst_pc stable, imem_req_valid=0 throughout.
//  3 br_taken, target 0x100, in WAIT; rsp 0xDEADBEEF next clk -> discarded, next imem_addr=0x100,
//    inst_valid=0 until the 0x100 response arrives.
//  4 br_taken (0x200) in same clk as inst_ready in HOLD at pc 0x10 -> next imem_addr=0x200, not 0x14.
//  5 br_taken, target 0x102 -> misaligned=1 for exactly one clk; next imem_addr=0x100.
//  6 rst asserted mid-WAIT -> inst_valid=0 and inst=NOP_INST before the next edge; first req RESET_PC.
//    Separately, pc=0xFFFF_FFFC accepted -> next imem_addr=0x0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: branch-type and fetch-state encodings plus reset defaults.
// No logic of its own; consumed by fetch and branch.
// Defaults are 32-bit and resized by users with a different address width.
package core_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

    // Branch condition selector shared with the branch comparator
    typedef enum logic [2:0] {
        BR_BEQ,
        BR_BNE,
        BR_BLT,
        BR_BGE,
        BR_BLTU,
        BR_BGEU,
        BR_PC,
        BR_ALU
    } br_type_e;

    // Fetch sequencer: issue request, wait for response, hold for decode
    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one memory request at a time, hands the word to decode.
// Latency: response to inst_valid 1 clk; decode accept to next request 1 clk.
// Backpressure: address held until imem_req_ready; inst held while inst_valid && !inst_ready.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter logic [31:0]     NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            misaligned
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    // Set when the in-flight response belongs to a PC that a redirect has since replaced
    logic            drop;

    // Request is only offered from REQ; reset forces it low immediately
    assign imem_req_valid = (state == REQ) && !rst;
    assign imem_addr      = pc;

    // Fetch sequencer, PC update and decode-side output registers; redirect outranks everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= REQ;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= RESET_PC;
            misaligned <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            if (br_taken) begin
                pc         <= {br_target[XLEN-1:2], 2'b00};
                inst_valid <= 1'b0;
                inst       <= NOP_INST;
                misaligned <= |br_target[1:0];
                case (state)
                    REQ: begin
                        // A request accepted alongside the redirect fetches the stale PC
                        if (imem_req_ready) begin
                            state <= WAIT;
                            drop  <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            state <= REQ;
                            drop  <= 1'b0;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end
                    HOLD:    state <= REQ;
                    default: state <= REQ;
                endcase
            end else begin
                case (state)
                    REQ: begin
                        if (imem_req_ready) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            if (drop) begin
                                drop  <= 1'b0;
                                state <= REQ;
                            end else begin
                                inst       <= imem_rsp_data;
                                inst_pc    <= pc;
                                inst_valid <= 1'b1;
                                state      <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (inst_ready) begin
                            inst_valid <= 1'b0;
                            inst       <= NOP_INST;
                            pc         <= pc + XLEN'(4);
                            state      <= REQ;
                        end
                    end
                    default: state <= REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory model with variable latency, random decode stalls
// and redirects; expected PCs are queued from accepts/redirects and popped when decode sees a new word.
// Memory words are a bijective function of address, so stale or dropped data shows up as a wrong word.
module tb_fetch_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misaligned;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misaligned     (misaligned)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc_q[$];
    logic        exp_mis = 1'b0;
    bit          done = 1'b0;

    // memory model state
    bit          pending = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          delay = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each newly presented instruction against the queue, plus per-cycle protocol rules
    logic        prev_valid = 1'b0;
    logic        prev_hold = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst = 32'h0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    int          idle = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst || done) begin
            prev_valid = 1'b0;
            prev_hold  = 1'b0;
            prev_stall = 1'b0;
            idle       = 0;
        end else begin
            check("misaligned", 32'(misaligned), 32'(exp_mis));
            if (inst_valid && !prev_valid) begin
                if (exp_pc_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_inst: got pc %08h want none at %0t", inst_pc, $time);
                end else begin
                    e = exp_pc_q.pop_front();
                    check("inst_pc", inst_pc, e);
                    check("inst", inst, mem_word(e));
                end
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout: got no inst for %0d clks want one at %0t", idle, $time);
                idle = 0;
            end
            if (prev_hold) begin
                check("hold_valid", 32'(inst_valid), 32'd1);
                check("hold_inst", inst, prev_inst);
                check("hold_pc", inst_pc, prev_pc);
            end
            if (!inst_valid) check("nop_when_idle", inst, NOP_INST_DEF);
            check("one_outstanding", 32'(imem_req_valid && inst_valid), 32'd0);
            if (prev_stall) begin
                check("req_held", 32'(imem_req_valid), 32'd1);
                check("addr_stable", imem_addr, prev_addr);
            end
            check("addr_align", 32'(imem_addr[1:0]), 32'd0);
            prev_valid = inst_valid;
            prev_hold  = inst_valid && !inst_ready && !br_taken;
            prev_inst  = inst;
            prev_pc    = inst_pc;
            prev_stall = imem_req_valid && !imem_req_ready && !br_taken;
            prev_addr  = imem_addr;
        end
    end

    // Reference model: what the next edge commits decides the next PC decode should see
    always @(negedge clk) begin
        #1;
        if (!rst && !done) begin
            exp_mis = br_taken && (br_target[1:0] != 2'b00);
            if (br_taken) begin
                exp_pc_q.delete();
                exp_pc_q.push_back({br_target[31:2], 2'b00});
            end else if (inst_valid && inst_ready) begin
                exp_pc_q.push_back(inst_pc + 32'd4);
            end
        end
    end

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom % 6)
            0:       t = 32'h0000_0100;
            1:       t = 32'h0000_0102;
            2:       t = 32'h0000_0200;
            3:       t = 32'hFFFF_FFFC;
            4:       t = 32'hFFFF_FFFE;
            default: t = $urandom;
        endcase
        return t;
    endfunction

    // One clock of stimulus: memory model bookkeeping plus fresh random inputs
    task automatic cycle(input int rdy_pct, input int ird_pct, input int br_pct,
                         input int max_delay, input int junk_pct);
        logic        hs;
        logic        rsp_now;
        logic [31:0] a;
        @(negedge clk);
        hs      = imem_req_valid && imem_req_ready;
        a       = imem_addr;
        rsp_now = imem_rsp_valid;
        @(posedge clk);
        #1;
        if (rsp_now) begin
            pending        = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        if (hs) begin
            pending = 1'b1;
            paddr   = a;
            delay   = $urandom_range(max_delay, 0);
        end
        if (pending) begin
            if (delay == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(paddr);
            end else begin
                delay--;
            end
        end else if (int'($urandom % 100) < junk_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = int'($urandom % 100) < rdy_pct;
        inst_ready     = int'($urandom % 100) < ird_pct;
        br_taken       = int'($urandom % 100) < br_pct;
        br_target      = pick_target();
    endtask

    task automatic check_reset_outputs();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, NOP_INST_DEF);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        br_taken       = 1'b0;
        br_target      = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        exp_pc_q.push_back(RESET_PC_DEF);
        #1;
        check_reset_outputs();
        check("rst_inst_pc", inst_pc, RESET_PC_DEF);
        check("rst_addr", imem_addr, RESET_PC_DEF);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // sequential fetch with ideal memory and decode
        repeat (20) cycle(100, 100, 0, 0, 0);
        // stalls and variable latency, no redirects
        repeat (300) cycle(60, 40, 0, 3, 10);
        // full random mix including redirects
        repeat (1500) cycle(60, 60, 8, 3, 10);

        // drive the fetch into WAIT with the response still outstanding, then reset
        begin
            int n;
            n = 0;
            while (!(pending && !imem_rsp_valid) && n < 100) begin
                cycle(100, 100, 0, 3, 0);
                n++;
            end
            if (n >= 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL reach_wait: got no WAIT in %0d clks want one", n);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        pending        = 1'b0;
        imem_rsp_valid = 1'b0;
        br_taken       = 1'b0;
        exp_pc_q.delete();
        exp_pc_q.push_back(RESET_PC_DEF);
        exp_mis = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (1500) cycle(60, 60, 8, 3, 10);

        done = 1'b1;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
